// File: rtl/axis_video_blend.sv
// Two-input AXI4-Stream video alpha blender.
// Resynchronises both sources to a common start-of-frame before blending,
// latches alpha and mode on every SOF beat, and drives a single fully
// back-pressured output register at one pixel per clock.
module axis_video_blend #(
  parameter int COMP_WIDTH  = 8,
  parameter int NUM_COMP    = 3,
  parameter int USER_WIDTH  = 1,
  parameter int ALPHA_WIDTH = 8
) (
  input  logic                             axis_clk,
  input  logic                             aresetn,
  input  logic [ALPHA_WIDTH-1:0]           alpha,
  input  logic [1:0]                       mode,
  input  logic [COMP_WIDTH*NUM_COMP-1:0]   s_axis_tdata_vid0,
  input  logic                             s_axis_tvalid_vid0,
  output logic                             s_axis_tready_vid0,
  input  logic                             s_axis_tlast_vid0,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser_vid0,
  input  logic [COMP_WIDTH*NUM_COMP-1:0]   s_axis_tdata_vid1,
  input  logic                             s_axis_tvalid_vid1,
  output logic                             s_axis_tready_vid1,
  input  logic                             s_axis_tlast_vid1,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser_vid1,
  output logic [COMP_WIDTH*NUM_COMP-1:0]   m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             frame_locked,
  output logic                             sync_err
);

  localparam int DATA_WIDTH = COMP_WIDTH * NUM_COMP;
  // Wide enough for v0*alpha + v1*(2^A - alpha) without overflow.
  localparam int PROD_WIDTH = COMP_WIDTH + ALPHA_WIDTH + 1;
  localparam logic [ALPHA_WIDTH-1:0] ALPHA_HALF = ALPHA_WIDTH'(1) << (ALPHA_WIDTH - 1);
  localparam logic [ALPHA_WIDTH:0]   ALPHA_ONE  = (ALPHA_WIDTH+1)'(1) << ALPHA_WIDTH;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [ALPHA_WIDTH-1:0] alpha_reg;
  logic [1:0]             mode_reg;
  // Keeps the input treadys low while reset is held and for the first edge after.
  logic                   active_reg;

  logic                   sof0;
  logic                   sof1;
  logic                   both_valid;
  logic                   user_match;
  logic                   slot_free;
  logic                   join_beat;
  logic                   user_err;
  logic                   last_err;
  logic                   frame_sof;
  logic [ALPHA_WIDTH-1:0] alpha_eff;
  logic [ALPHA_WIDTH:0]   alpha_inv;
  logic [1:0]             mode_eff;
  logic [DATA_WIDTH-1:0]  blend_data;
  logic [DATA_WIDTH-1:0]  out_data_next;

  assign sof0       = s_axis_tvalid_vid0 & s_axis_tuser_vid0[0];
  assign sof1       = s_axis_tvalid_vid1 & s_axis_tuser_vid1[0];
  assign both_valid = s_axis_tvalid_vid0 & s_axis_tvalid_vid1;
  assign user_match = (s_axis_tuser_vid0[0] == s_axis_tuser_vid1[0]);
  assign slot_free  = ~m_axis_tvalid | m_axis_tready;

  assign join_beat  = (state_reg == ST_RUN) & both_valid & user_match & slot_free;
  assign user_err   = (state_reg == ST_RUN) & both_valid & ~user_match;
  assign last_err   = join_beat & (s_axis_tlast_vid0 != s_axis_tlast_vid1);

  // In SYNC each input drains non-SOF beats and parks on its SOF; in RUN both move together.
  always_comb begin
    s_axis_tready_vid0 = 1'b0;
    s_axis_tready_vid1 = 1'b0;
    if (state_reg == ST_SYNC) begin
      s_axis_tready_vid0 = active_reg & ~sof0;
      s_axis_tready_vid1 = active_reg & ~sof1;
    end else begin
      s_axis_tready_vid0 = join_beat;
      s_axis_tready_vid1 = join_beat;
    end
  end

  // The SOF pixel already uses the newly presented frame parameters.
  assign frame_sof = s_axis_tuser_vid0[0];
  assign alpha_eff = frame_sof ? alpha : alpha_reg;
  assign mode_eff  = frame_sof ? mode  : mode_reg;
  assign alpha_inv = ALPHA_ONE - {1'b0, alpha_eff};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COMP; gi++) begin : g_comp
      logic [COMP_WIDTH-1:0] v0_c;
      logic [COMP_WIDTH-1:0] v1_c;
      logic [PROD_WIDTH-1:0] acc;
      assign v0_c = s_axis_tdata_vid0[gi*COMP_WIDTH +: COMP_WIDTH];
      assign v1_c = s_axis_tdata_vid1[gi*COMP_WIDTH +: COMP_WIDTH];
      assign acc  = PROD_WIDTH'(v0_c) * PROD_WIDTH'(alpha_eff)
                  + PROD_WIDTH'(v1_c) * PROD_WIDTH'(alpha_inv);
      assign blend_data[gi*COMP_WIDTH +: COMP_WIDTH] = acc[ALPHA_WIDTH +: COMP_WIDTH];
    end
  endgenerate

  // Pass modes copy the selected source untouched; 11 falls back to blending.
  always_comb begin
    out_data_next = blend_data;
    case (mode_eff)
      2'b01:   out_data_next = s_axis_tdata_vid0;
      2'b10:   out_data_next = s_axis_tdata_vid1;
      default: out_data_next = blend_data;
    endcase
  end

  assign frame_locked = (state_reg == ST_RUN);

  // Sync FSM, frame parameter latch and the output register.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= ST_SYNC;
      alpha_reg     <= ALPHA_HALF;
      mode_reg      <= 2'b00;
      active_reg    <= 1'b0;
      sync_err      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      active_reg <= 1'b1;
      sync_err   <= 1'b0;

      if (join_beat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= out_data_next;
        m_axis_tlast  <= s_axis_tlast_vid0 & s_axis_tlast_vid1;
        m_axis_tuser  <= s_axis_tuser_vid0 & s_axis_tuser_vid1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (join_beat && frame_sof) begin
        alpha_reg <= alpha;
        mode_reg  <= mode;
      end

      case (state_reg)
        ST_SYNC: begin
          if (sof0 && sof1) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (user_err || last_err) begin
            sync_err  <= 1'b1;
            state_reg <= ST_SYNC;
          end
        end
        default: state_reg <= ST_SYNC;
      endcase
    end
  end

endmodule
